// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin scheduler granting one of eight requesters a burst-limited
// slot on a shared 8:1 datapath and a single ready/valid output port.
module mux8_rr_sched #(
   parameter int DW = 8,
   parameter int BURST = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      req,
   input  logic [8*DW-1:0] data,
   input  logic            out_ready,
   output logic [2:0]      sel,
   output logic [7:0]      gnt,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic [2:0]      out_src
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state, state_nx;
   logic [2:0] ptr, ptr_nx, sel_nx, pick;
   logic [7:0] gnt_nx;
   logic [3:0] cnt, cnt_nx;
   logic found, xfer, rel;
   always_comb begin
      pick = ptr;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (!found && req[3'(ptr + 3'(k))]) begin
            pick = 3'(ptr + 3'(k));
            found = 1'b1;
         end
      end
   end
   assign out_valid = (state == GRANT) && req[sel];
   assign xfer      = out_valid && out_ready;
   assign rel       = (state == GRANT) && (!req[sel] || (xfer && cnt == 4'(BURST - 1)));
   assign out_data  = data[sel*DW +: DW];
   assign out_src   = sel;
   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      gnt_nx   = gnt;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      if (state == IDLE) begin
         if (found) begin
            state_nx = GRANT;
            sel_nx   = pick;
            gnt_nx   = 8'd1 << pick;
            cnt_nx   = '0;
         end
      end else if (rel) begin
         // every grant returns to IDLE for one cycle; the pointer moves past the grantee
         state_nx = IDLE;
         gnt_nx   = '0;
         cnt_nx   = '0;
         ptr_nx   = sel + 3'd1;
      end else if (xfer) begin
         cnt_nx = cnt + 4'd1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sel   <= '0;
         gnt   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         sel   <= sel_nx;
         gnt   <= gnt_nx;
         ptr   <= ptr_nx;
         cnt   <= cnt_nx;
      end
   end
endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb_mux8_rr_sched: drives a BURST=4 and a BURST=1 scheduler with directed and random
// traffic, comparing every cycle against a grant/beat reference model.
module tb_mux8_rr_sched;
   logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
   logic [7:0] req = '0;
   logic [63:0] data = '0;
   logic [2:0] sel_o[2], src_o[2];
   logic [7:0] gnt_o[2], dat_o[2];
   logic val_o[2];
   int npass = 0, ntot = 0;
   int mgr[2], mcnt[2], mptr[2], msel[2];
   always #5 clk = ~clk;
   mux8_rr_sched #(.DW(8), .BURST(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req(req), .data(data), .out_ready(out_ready),
      .sel(sel_o[0]), .gnt(gnt_o[0]), .out_valid(val_o[0]), .out_data(dat_o[0]), .out_src(src_o[0]));
   mux8_rr_sched #(.DW(8), .BURST(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .data(data), .out_ready(out_ready),
      .sel(sel_o[1]), .gnt(gnt_o[1]), .out_valid(val_o[1]), .out_data(dat_o[1]), .out_src(src_o[1]));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntot++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask
   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mgr[k] = -1;
         mcnt[k] = 0;
         mptr[k] = 0;
         msel[k] = 0;
      end
   endtask
   task automatic compare();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("gnt[b%0d]", k), gnt_o[k], 32'(mgr[k] < 0 ? 0 : 1 << mgr[k]));
         check($sformatf("sel[b%0d]", k), sel_o[k], 32'(msel[k]));
         check($sformatf("out_src[b%0d]", k), src_o[k], 32'(msel[k]));
         check($sformatf("out_valid[b%0d]", k), val_o[k], 32'(mgr[k] >= 0 ? req[mgr[k]] : 1'b0));
         check($sformatf("out_data[b%0d]", k), dat_o[k], 32'(data[msel[k]*8 +: 8]));
      end
   endtask
   // what the coming clock edge does to each scheduler
   task automatic advance();
      for (int k = 0; k < 2; k++) begin
         int b;
         b = k ? 1 : 4;
         if (!rst_n) continue;
         if (mgr[k] < 0) begin
            for (int j = 0; j < 8; j++)
               if (mgr[k] < 0 && req[(mptr[k] + j) % 8]) begin
                  mgr[k] = (mptr[k] + j) % 8;
                  msel[k] = mgr[k];
                  mcnt[k] = 0;
               end
         end else begin
            if (req[mgr[k]] && out_ready) mcnt[k]++;
            if (!req[mgr[k]] || mcnt[k] == b) begin
               mptr[k] = (mgr[k] + 1) % 8;
               mgr[k] = -1;
               mcnt[k] = 0;
            end
         end
      end
   endtask
   task automatic step(input logic rn, input logic [7:0] r, input logic rdy, input bit fixed);
      @(negedge clk);
      rst_n = rn;
      if (!rn) model_reset();
      req = r;
      out_ready = rdy;
      for (int i = 0; i < 8; i++) data[i*8 +: 8] = fixed ? 8'(8'hA0 + i) : 8'($urandom);
      #1 compare();
      advance();
   endtask
   initial begin
      model_reset();
      repeat (3) step(1'b0, 8'hFF, 1'b1, 1'b1);
      repeat (90) step(1'b1, 8'hFF, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (6) step(1'b1, 8'h20, 1'b1, 1'b0);
      repeat (14) step(1'b1, 8'h21, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (14) step(1'b1, 8'h08, 1'b0, 1'b0);
      repeat (4) step(1'b1, 8'h00, 1'b1, 1'b0);
      repeat (12) step(1'b1, 8'h10, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (3) step(1'b1, 8'h20, 1'b1, 1'b0);
      // asynchronous reset in the middle of a cycle, checked before the next edge
      rst_n = 1'b0;
      model_reset();
      #1 compare();
      step(1'b0, 8'hFF, 1'b1, 1'b0);
      repeat (12) step(1'b1, 8'hFF, 1'b1, 1'b0);
      repeat (500) step($urandom_range(99, 0) != 0, 8'($urandom) | 8'($urandom),
                        $urandom_range(3, 0) != 0, 1'b0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
